// File: rtl/decode_pkg.sv
// Shared definitions for the instruction-decode stage: default widths,
// instruction field positions, opcodes, control-bundle bit indices and the
// opcode-to-control decoder.
package decode_pkg;

    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_ADDR_W  = 3;
    localparam int unsigned DEF_STALL_W = 16;

    // Instruction layout: [15:12]op [11:9]rs [8:6]rt [5:3]rd [2:0]funct, imm=[5:0]
    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned FUNCT_W   = 3;
    localparam int unsigned IMM_W     = 6;
    localparam int unsigned OP_LSB    = 12;
    localparam int unsigned RS_LSB    = 9;
    localparam int unsigned RT_LSB    = 6;
    localparam int unsigned RD_LSB    = 3;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned IMM_LSB   = 0;

    localparam logic [OP_W-1:0] OP_RTYPE = 4'd0;
    localparam logic [OP_W-1:0] OP_ADDI  = 4'd1;
    localparam logic [OP_W-1:0] OP_LW    = 4'd2;
    localparam logic [OP_W-1:0] OP_SW    = 4'd3;
    localparam logic [OP_W-1:0] OP_BEQ   = 4'd4;

    // Control-bundle bit indices
    localparam int unsigned CTL_REG_WRITE = 0;
    localparam int unsigned CTL_MEM_READ  = 1;
    localparam int unsigned CTL_MEM_WRITE = 2;
    localparam int unsigned CTL_ALU_SRC   = 3;
    localparam int unsigned CTL_BRANCH    = 4;
    localparam int unsigned CTL_ILLEGAL   = 5;
    localparam int unsigned CTL_USE_RS    = 6;
    localparam int unsigned CTL_USE_RT    = 7;
    localparam int unsigned CTL_DEST_RD   = 8;
    localparam int unsigned CTL_W         = 9;

    // Opcode to control bundle; unknown opcodes only raise ILLEGAL.
    function automatic logic [CTL_W-1:0] decode_ctrl(input logic [OP_W-1:0] op);
        logic [CTL_W-1:0] c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c[CTL_REG_WRITE] = 1'b1;
                c[CTL_USE_RS]    = 1'b1;
                c[CTL_USE_RT]    = 1'b1;
                c[CTL_DEST_RD]   = 1'b1;
            end
            OP_ADDI: begin
                c[CTL_REG_WRITE] = 1'b1;
                c[CTL_ALU_SRC]   = 1'b1;
                c[CTL_USE_RS]    = 1'b1;
            end
            OP_LW: begin
                c[CTL_REG_WRITE] = 1'b1;
                c[CTL_MEM_READ]  = 1'b1;
                c[CTL_ALU_SRC]   = 1'b1;
                c[CTL_USE_RS]    = 1'b1;
            end
            OP_SW: begin
                c[CTL_MEM_WRITE] = 1'b1;
                c[CTL_ALU_SRC]   = 1'b1;
                c[CTL_USE_RS]    = 1'b1;
                c[CTL_USE_RT]    = 1'b1;
            end
            OP_BEQ: begin
                c[CTL_BRANCH]    = 1'b1;
                c[CTL_USE_RS]    = 1'b1;
                c[CTL_USE_RT]    = 1'b1;
            end
            default: c[CTL_ILLEGAL] = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_hazard_unit.sv
// Combinational hazard detection for the decode stage.
//   ex_valid/ex_mem_read/ex_dest : instruction currently held in ID/EX
//   rs/rt, use_rs/use_rt         : sources of the decoding instruction and whether they are read
//   wb_reg_write/wb_addr         : writeback in flight this cycle
//   wb_hit_rs_c/wb_hit_rt_c      : writeback targets a used source
//   stall_c                      : decode must not accept this cycle
// Macro DECODE_WB_BYPASS_EN: writeback matches are forwarded by the caller
// instead of stalling.
module decode_hazard_unit
    import decode_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [ADDR_W-1:0] ex_dest,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic              use_rs,
    input  logic              use_rt,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic              wb_hit_rs_c,
    output logic              wb_hit_rt_c,
    output logic              stall_c
);

    logic load_use_c;

    always_comb begin
        load_use_c  = ex_valid && ex_mem_read &&
                      ((use_rs && (ex_dest == rs)) || (use_rt && (ex_dest == rt)));
        wb_hit_rs_c = wb_reg_write && use_rs && (wb_addr == rs);
        wb_hit_rt_c = wb_reg_write && use_rt && (wb_addr == rt);
`ifdef DECODE_WB_BYPASS_EN
        stall_c     = load_use_c;
`else
        // Register file read data is stale while a write to it is in progress.
        stall_c     = load_use_c || wb_hit_rs_c || wb_hit_rt_c;
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: splits the IF/ID instruction, drives register
// file read addresses, sign-extends the immediate, generates control and
// captures everything into the ID/EX register under valid/ready.
//   clk, rst_n (sync, active-low)
//   if_valid/if_instr/if_pc -> id_ready (comb accept)
//   flush kills the stage; ex_ready is backpressure from EX
//   rf_rd_addr1/2 (comb) -> rf_data1/2; wb_reg_write/wb_addr/wb_data writeback
//   ex_* registered ID/EX bundle; stall_count saturating hazard-stall count
// Macro DECODE_WB_BYPASS_EN: forward wb_data on a writeback match instead of stalling.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned STALL_W = DEF_STALL_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_valid,
    input  logic [INSTR_W-1:0]  if_instr,
    input  logic [DATA_W-1:0]   if_pc,
    output logic                id_ready,
    input  logic                flush,
    input  logic                ex_ready,
    output logic [ADDR_W-1:0]   rf_rd_addr1,
    output logic [ADDR_W-1:0]   rf_rd_addr2,
    input  logic [DATA_W-1:0]   rf_data1,
    input  logic [DATA_W-1:0]   rf_data2,
    input  logic                wb_reg_write,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    output logic                ex_valid,
    output logic [DATA_W-1:0]   ex_pc,
    output logic [DATA_W-1:0]   ex_data1,
    output logic [DATA_W-1:0]   ex_data2,
    output logic [DATA_W-1:0]   ex_imm,
    output logic [OP_W-1:0]     ex_opcode,
    output logic [FUNCT_W-1:0]  ex_funct,
    output logic [ADDR_W-1:0]   ex_dest,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_alu_src,
    output logic                ex_branch,
    output logic                ex_illegal,
    output logic [STALL_W-1:0]  stall_count
);

    // Field split
    logic [OP_W-1:0]    op_c;
    logic [ADDR_W-1:0]  rs_c, rt_c, rd_c, dest_c;
    logic [FUNCT_W-1:0] funct_c;
    logic [IMM_W-1:0]   imm_c;
    logic [CTL_W-1:0]   ctl_c;

    assign op_c        = if_instr[OP_LSB +: OP_W];
    assign rs_c        = if_instr[RS_LSB +: ADDR_W];
    assign rt_c        = if_instr[RT_LSB +: ADDR_W];
    assign rd_c        = if_instr[RD_LSB +: ADDR_W];
    assign funct_c     = if_instr[FUNCT_LSB +: FUNCT_W];
    assign imm_c       = if_instr[IMM_LSB +: IMM_W];
    assign ctl_c       = decode_ctrl(op_c);
    assign dest_c      = ctl_c[CTL_DEST_RD] ? rd_c : rt_c;
    assign rf_rd_addr1 = rs_c;
    assign rf_rd_addr2 = rt_c;

    logic wb_hit_rs_c, wb_hit_rt_c, stall_c;

    decode_hazard_unit #(.ADDR_W(ADDR_W)) u_hazard (
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_dest      (ex_dest),
        .rs           (rs_c),
        .rt           (rt_c),
        .use_rs       (ctl_c[CTL_USE_RS]),
        .use_rt       (ctl_c[CTL_USE_RT]),
        .wb_reg_write (wb_reg_write),
        .wb_addr      (wb_addr),
        .wb_hit_rs_c  (wb_hit_rs_c),
        .wb_hit_rt_c  (wb_hit_rt_c),
        .stall_c      (stall_c)
    );

    // Operand select, handshake and stall accounting
    logic [DATA_W-1:0] data1_c, data2_c, imm_ext_c;
    logic advance_c, hazard_c, accept_c, bubble_stall_c;

    always_comb begin
        // Without the bypass macro a hit always stalls, so wb_data is never captured.
        data1_c        = wb_hit_rs_c ? wb_data : rf_data1;
        data2_c        = wb_hit_rt_c ? wb_data : rf_data2;
        imm_ext_c      = {{(DATA_W-IMM_W){imm_c[IMM_W-1]}}, imm_c};
        advance_c      = !ex_valid || ex_ready;
        hazard_c       = if_valid && stall_c;
        // Flush acknowledges the IF/ID instruction so it is dropped.
        id_ready       = rst_n && (flush || (advance_c && !hazard_c));
        accept_c       = if_valid && advance_c && !hazard_c && !flush;
        bubble_stall_c = hazard_c && advance_c && !flush;
    end

    // ID/EX register and stall counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_data1     <= '0;
            ex_data2     <= '0;
            ex_imm       <= '0;
            ex_opcode    <= '0;
            ex_funct     <= '0;
            ex_dest      <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_alu_src   <= 1'b0;
            ex_branch    <= 1'b0;
            ex_illegal   <= 1'b0;
            stall_count  <= '0;
        end else begin
            if (bubble_stall_c && (stall_count != '1)) begin
                stall_count <= stall_count + STALL_W'(1);
            end
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (advance_c) begin
                ex_valid <= accept_c;
                if (accept_c) begin
                    ex_pc        <= if_pc;
                    ex_data1     <= data1_c;
                    ex_data2     <= data2_c;
                    ex_imm       <= imm_ext_c;
                    ex_opcode    <= op_c;
                    ex_funct     <= funct_c;
                    ex_dest      <= dest_c;
                    ex_reg_write <= ctl_c[CTL_REG_WRITE];
                    ex_mem_read  <= ctl_c[CTL_MEM_READ];
                    ex_mem_write <= ctl_c[CTL_MEM_WRITE];
                    ex_alu_src   <= ctl_c[CTL_ALU_SRC];
                    ex_branch    <= ctl_c[CTL_BRANCH];
                    ex_illegal   <= ctl_c[CTL_ILLEGAL];
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a behavioural model tracks the
// expected ID/EX bundle, id_ready and stall count every cycle; directed
// sequences add literal expectations. Honors DECODE_WB_BYPASS_EN.
module tb_decode_stage;

    localparam int unsigned STW = 4;   // narrow counter so saturation is reachable

    logic        clk = 1'b0;
    logic        rst_n, if_valid, flush, ex_ready, wb_reg_write;
    logic [15:0] if_instr, if_pc, rf_data1, rf_data2, wb_data;
    logic [2:0]  wb_addr;
    logic        id_ready;
    logic [2:0]  rf_rd_addr1, rf_rd_addr2;
    logic        ex_valid;
    logic [15:0] ex_pc, ex_data1, ex_data2, ex_imm;
    logic [3:0]  ex_opcode;
    logic [2:0]  ex_funct, ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch, ex_illegal;
    logic [STW-1:0] stall_count;

    decode_stage #(.DATA_W(16), .ADDR_W(3), .STALL_W(STW)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready),
        .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_reg_write(wb_reg_write), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_data1(ex_data1), .ex_data2(ex_data2),
        .ex_imm(ex_imm), .ex_opcode(ex_opcode), .ex_funct(ex_funct), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_illegal(ex_illegal),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          v;
        logic [15:0] pc, d1, d2, imm;
        logic [3:0]  op;
        logic [2:0]  fn, dest;
        bit          rw, mr, mw, as, br, il;
    } bundle_t;

    bundle_t        m;
    logic [STW-1:0] m_stall;
    bit             m_fresh = 1'b0;   // last edge was a reset edge
    bit             m_init  = 1'b0;

`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    function automatic bit reads_rs(input logic [3:0] op);
        return op <= 4'd4;
    endfunction

    function automatic bit reads_rt(input logic [3:0] op);
        return (op == 4'd0) || (op == 4'd3) || (op == 4'd4);
    endfunction

    function automatic bit wb_match(input logic [15:0] ins, input bit rs_side);
        logic [3:0] op;
        logic [2:0] r;
        op = ins[15:12];
        r  = rs_side ? ins[11:9] : ins[8:6];
        return wb_reg_write && (wb_addr == r) && (rs_side ? reads_rs(op) : reads_rt(op));
    endfunction

    function automatic bit model_hazard();
        logic [3:0] op;
        bit lu, wb;
        op = if_instr[15:12];
        lu = m.v && m.mr && ((reads_rs(op) && m.dest == if_instr[11:9]) ||
                             (reads_rt(op) && m.dest == if_instr[8:6]));
        wb = !BYPASS && (wb_match(if_instr, 1'b1) || wb_match(if_instr, 1'b0));
        return if_valid && (lu || wb);
    endfunction

    function automatic bit model_ready();
        return rst_n && (flush || ((!m.v || ex_ready) && !model_hazard()));
    endfunction

    function automatic bundle_t expected_bundle();
        bundle_t b;
        logic [5:0] im;
        b = '{default: '0};
        im     = if_instr[5:0];
        b.v    = 1'b1;
        b.pc   = if_pc;
        b.op   = if_instr[15:12];
        b.fn   = if_instr[2:0];
        b.imm  = 16'($signed(im));
        b.d1   = (BYPASS && wb_match(if_instr, 1'b1)) ? wb_data : rf_data1;
        b.d2   = (BYPASS && wb_match(if_instr, 1'b0)) ? wb_data : rf_data2;
        b.dest = if_instr[8:6];
        case (b.op)
            4'd0: begin b.rw = 1; b.dest = if_instr[5:3]; end
            4'd1: begin b.rw = 1; b.as = 1; end
            4'd2: begin b.rw = 1; b.mr = 1; b.as = 1; end
            4'd3: begin b.mw = 1; b.as = 1; end
            4'd4: b.br = 1;
            default: b.il = 1;
        endcase
        return b;
    endfunction

    always @(posedge clk) begin
        bit adv, hz;
        m_init = 1'b1;
        if (!rst_n) begin
            m       = '{default: '0};
            m_stall = '0;
            m_fresh = 1'b1;
        end else begin
            adv     = !m.v || ex_ready;
            hz      = model_hazard();
            m_fresh = 1'b0;
            if (!flush && adv && hz && m_stall != {STW{1'b1}}) m_stall = m_stall + 1'b1;
            if (flush) m.v = 1'b0;
            else if (adv) begin
                if (if_valid && !hz) m = expected_bundle();
                else m.v = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("ex_valid", 32'(ex_valid), 32'(m.v));
            chk("stall_count", 32'(stall_count), 32'(m_stall));
            chk("id_ready", 32'(id_ready), 32'(model_ready()));
            chk("rf_rd_addr1", 32'(rf_rd_addr1), 32'(if_instr[11:9]));
            chk("rf_rd_addr2", 32'(rf_rd_addr2), 32'(if_instr[8:6]));
            if (m.v || m_fresh) begin
                chk("ex_pc", 32'(ex_pc), 32'(m.pc));
                chk("ex_data1", 32'(ex_data1), 32'(m.d1));
                chk("ex_data2", 32'(ex_data2), 32'(m.d2));
                chk("ex_imm", 32'(ex_imm), 32'(m.imm));
                chk("ex_opcode", 32'(ex_opcode), 32'(m.op));
                chk("ex_funct", 32'(ex_funct), 32'(m.fn));
                chk("ex_dest", 32'(ex_dest), 32'(m.dest));
                chk("ex_ctl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch, ex_illegal}),
                    32'({m.rw, m.mr, m.mw, m.as, m.br, m.il}));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    localparam logic [15:0] I_ADDI = 16'h107D;  // ADDI r1,r0,-3
    localparam logic [15:0] I_LW   = 16'h2080;  // LW r2,0(r0)
    localparam logic [15:0] I_ADD  = 16'h0458;  // ADD r3,r2,r1
    localparam logic [15:0] I_ADD2 = 16'h0298;  // ADD r3,r1,r2
    localparam logic [15:0] I_SW   = 16'h3284;  // SW r2,4(r1)
    localparam logic [15:0] I_BEQ  = 16'h497F;  // BEQ r4,r5,-1
    localparam logic [15:0] I_BAD  = 16'hF000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [15:0] ins, input logic [15:0] pc);
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
    endtask

    initial begin
        rst_n = 0; if_valid = 0; if_instr = 16'h0; if_pc = 16'h0; flush = 0; ex_ready = 1;
        rf_data1 = 16'h0; rf_data2 = 16'h0; wb_reg_write = 0; wb_addr = 3'd0; wb_data = 16'h0;

        // Reset
        tick(); tick();
        chk("rst id_ready", 32'(id_ready), 32'h0);
        chk("rst ex_valid", 32'(ex_valid), 32'h0);
        chk("rst stall_count", 32'(stall_count), 32'h0);
        rst_n = 1;

        // 1: ADDI sign extension
        drive(1, I_ADDI, 16'h0100); rf_data1 = 16'h0001; rf_data2 = 16'h00AA;
        tick();
        chk("t1 ex_imm", 32'(ex_imm), 32'hFFFD);
        chk("t1 ex_dest", 32'(ex_dest), 32'h1);
        chk("t1 alu_src/reg_write", 32'({ex_alu_src, ex_reg_write}), 32'h3);
        chk("t1 ex_data1", 32'(ex_data1), 32'h0001);

        // 2: load-use bubble
        drive(1, I_LW, 16'h0102); tick();
        drive(1, I_ADD, 16'h0104); #1;
        chk("t2 id_ready", 32'(id_ready), 32'h0);
        tick();
        chk("t2 bubble", 32'(ex_valid), 32'h0);
        chk("t2 stall_count", 32'(stall_count), 32'h1);
        tick();
        chk("t2 add issued", 32'({ex_valid, ex_opcode, ex_dest}), {24'h0, 1'b1, 4'h0, 3'd3});

        // 3: EX backpressure
        drive(1, I_SW, 16'h0106); tick();
        ex_ready = 0; drive(1, I_BEQ, 16'h0108);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3 id_ready", 32'(id_ready), 32'h0);
            tick();
            chk("t3 hold", 32'({ex_valid, ex_opcode, ex_mem_write}), {27'h0, 1'b1, 4'h3, 1'b1});
        end
        ex_ready = 1; #1;
        chk("t3 release id_ready", 32'(id_ready), 32'h1);
        tick();
        chk("t3 beq", 32'({ex_opcode, ex_branch, ex_imm}), {11'h0, 4'h4, 1'b1, 16'hFFFF});

        // 4: flush beats a pending load-use hazard
        drive(1, I_LW, 16'h010A); tick();
        drive(1, I_ADD, 16'h010C); flush = 1; #1;
        chk("t4 id_ready", 32'(id_ready), 32'h1);
        tick();
        chk("t4 ex_valid", 32'(ex_valid), 32'h0);
        chk("t4 stall_count", 32'(stall_count), 32'h1);
        flush = 0; drive(0, I_ADD, 16'h010C); tick();

        // 5: writeback match on rs
        drive(1, I_ADD2, 16'h010E); rf_data1 = 16'h0000; rf_data2 = 16'h0022;
        wb_reg_write = 1; wb_addr = 3'd1; wb_data = 16'h1234;
        tick();
`ifdef DECODE_WB_BYPASS_EN
        chk("t5 bypass", 32'({ex_valid, ex_data1}), {15'h0, 1'b1, 16'h1234});
        wb_reg_write = 0;
`else
        chk("t5 bubble", 32'(ex_valid), 32'h0);
        chk("t5 stall_count", 32'(stall_count), 32'h2);
        wb_reg_write = 0; rf_data1 = 16'h1234;
        tick();
        chk("t5 retry", 32'({ex_valid, ex_data1}), {15'h0, 1'b1, 16'h1234});
`endif

        // 6: illegal opcode
        drive(1, I_BAD, 16'h0110); tick();
        chk("t6 illegal", 32'({ex_illegal, ex_reg_write, ex_mem_write, ex_mem_read}), 32'h8);

        // Reset in the middle of a stall
        drive(1, I_LW, 16'h0112); tick();
        ex_ready = 0; drive(1, I_ADD, 16'h0114); tick();
        chk("rst-stall hold", 32'(ex_opcode), 32'h2);
        rst_n = 0; #1;
        chk("rst-stall id_ready", 32'(id_ready), 32'h0);
        tick();
        chk("rst-stall clear", 32'({ex_valid, stall_count, ex_pc, ex_imm, ex_mem_read}), 32'h0);
        rst_n = 1; ex_ready = 1; tick();
        chk("post-rst issue", 32'({ex_valid, ex_opcode, ex_dest}), {24'h0, 1'b1, 4'h0, 3'd3});

        // Saturation: one hazard stall per LW/ADD pair
        for (int i = 0; i < 20; i++) begin
            drive(1, I_LW, 16'h0200); tick();
            drive(1, I_ADD, 16'h0202); tick(); tick();
        end
        chk("saturated", 32'(stall_count), 32'hF);

        drive(0, 16'h0, 16'h0); tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
